// File: rtl/rv_defs_pkg.sv
// Shared RV32 decode definitions: opcode constants, write-back encodings,
// instruction formats and the decoded-instruction payload.
package rv_defs;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned OPC_W = 5;

   localparam logic [OPC_W-1:0] OPC_LOAD     = 5'b00000;
   localparam logic [OPC_W-1:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [OPC_W-1:0] OPC_AUIPC    = 5'b00101;
   localparam logic [OPC_W-1:0] OPC_STORE    = 5'b01000;
   localparam logic [OPC_W-1:0] OPC_OP       = 5'b01100;
   localparam logic [OPC_W-1:0] OPC_LUI      = 5'b01101;
   localparam logic [OPC_W-1:0] OPC_BRANCH   = 5'b11000;
   localparam logic [OPC_W-1:0] OPC_JALR     = 5'b11001;
   localparam logic [OPC_W-1:0] OPC_JAL      = 5'b11011;
   localparam logic [OPC_W-1:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_RET  = 2'b10;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

   typedef struct packed {
      logic [XLEN-1:0]  immediate;
      logic [OPC_W-1:0] opcode;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [REG_W-1:0] rsa;
      logic [REG_W-1:0] rsb;
      logic [REG_W-1:0] rd;
      logic             system;
      logic             mul;
      logic             illegal;
      logic             alu_pc;
      logic             alu_imm;
      logic             alu_en;
      logic             ma_wr;
      logic             ma_rd;
      logic [1:0]       wb_mux;
      logic             wb_en;
   } dec_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } sb_entry_t;

endpackage

// File: rtl/decode_stage_logic.sv
// Purely combinational RV32 field, immediate, control and legality decode,
// plus the source-operand use flags consumed by the hazard check.
module decode_logic
   import rv_defs::*;
#(
   parameter bit DECODE_SYSTEM = 1'b1,
   parameter bit DECODE_MUL    = 1'b0
) (
   input  logic [XLEN-1:0] insn,
   output dec_t            dec_c,
   output logic            uses_a_c,
   output logic            uses_b_c
);

   logic [OPC_W-1:0] opc;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic             known;
   logic             f7_ok;
   logic             legal;
   logic             mul_enc;
   fmt_e             fmt;
   logic [XLEN-1:0]  imm;

   always_comb begin
      opc     = insn[6:2];
      f3      = insn[14:12];
      f7      = insn[31:25];
      known   = 1'b0;
      f7_ok   = 1'b1;
      fmt     = FMT_R;
      mul_enc = (f7 == 7'b0000001);

      case (opc)
         OPC_LUI, OPC_AUIPC: begin known = 1'b1; fmt = FMT_U; end
         OPC_JAL:            begin known = 1'b1; fmt = FMT_J; end
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM:
                             begin known = 1'b1; fmt = FMT_I; end
         OPC_BRANCH:         begin known = 1'b1; fmt = FMT_B; end
         OPC_STORE:          begin known = 1'b1; fmt = FMT_S; end
         OPC_OP: begin
            known = 1'b1;
            fmt   = FMT_R;
            // funct7=0100000 only exists for SUB and SRA
            f7_ok = (f7 == 7'b0000000)
                 || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))
                 || (DECODE_MUL && mul_enc);
         end
         OPC_SYSTEM:         begin known = DECODE_SYSTEM; fmt = FMT_I; end
         default:            begin known = 1'b0; fmt = FMT_R; end
      endcase

      legal = (insn[1:0] == 2'b11) && known && f7_ok;

      case (fmt)
         FMT_I:   imm = {{20{insn[31]}}, insn[31:20]};
         FMT_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         FMT_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         FMT_U:   imm = {insn[31:12], 12'h000};
         FMT_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default: imm = '0;
      endcase

      dec_c           = '0;
      dec_c.immediate = legal ? imm : '0;
      dec_c.opcode    = opc;
      dec_c.funct3    = f3;
      dec_c.funct7    = f7;
      dec_c.rsa       = (opc == OPC_LUI) ? '0 : insn[19:15];
      dec_c.rsb       = insn[24:20];
      dec_c.rd        = insn[11:7];
      dec_c.illegal   = !legal;
      dec_c.system    = legal && (opc == OPC_SYSTEM);
      dec_c.mul       = legal && DECODE_MUL && (opc == OPC_OP) && mul_enc;
      dec_c.alu_pc    = (opc == OPC_JAL) || (opc == OPC_AUIPC) || (opc == OPC_BRANCH);
      dec_c.alu_imm   = (opc != OPC_OP);
      dec_c.alu_en    = ((opc == OPC_OP) || (opc == OPC_OP_IMM)) && !dec_c.mul;
      dec_c.ma_wr     = legal && (opc == OPC_STORE);
      dec_c.ma_rd     = legal && (opc == OPC_LOAD);
      dec_c.wb_mux    = {(opc == OPC_JAL) || (opc == OPC_JALR), (opc == OPC_LOAD)};
      dec_c.wb_en     = legal && (opc != OPC_STORE) && (opc != OPC_BRANCH);

      uses_a_c = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
      uses_b_c = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: valid/ready handshake, output register and a
// shift-register scoreboard of in-flight destinations that stalls RAW hazards.
module decode_stage
   import rv_defs::*;
#(
   parameter bit          DECODE_SYSTEM = 1'b1,
   parameter bit          DECODE_MUL    = 1'b0,
   parameter int unsigned HZ_DEPTH      = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [XLEN-1:0]  i_opcode_in,
   input  logic [XLEN-1:0]  i_pc,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_pc,
   output logic [XLEN-1:0]  o_immediate,
   output logic [OPC_W-1:0] o_opcode,
   output logic [2:0]       o_funct3,
   output logic [6:0]       o_funct7,
   output logic [REG_W-1:0] o_rsa,
   output logic [REG_W-1:0] o_rsb,
   output logic [REG_W-1:0] o_rd,
   output logic             o_system,
   output logic             o_mul,
   output logic             o_illegal,
   output logic             o_alu_pc,
   output logic             o_alu_imm,
   output logic             o_alu_en,
   output logic             o_ma_wr,
   output logic             o_ma_rd,
   output logic [1:0]       o_wb_mux,
   output logic             o_wb_en
);

   dec_t            dec_c;
   logic            uses_a_c;
   logic            uses_b_c;
   dec_t            out_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;
   sb_entry_t       sb_q [HZ_DEPTH];
   logic            match_a;
   logic            match_b;
   logic            hazard;
   logic            accept;

   decode_logic #(
      .DECODE_SYSTEM (DECODE_SYSTEM),
      .DECODE_MUL    (DECODE_MUL)
   ) u_decode_logic (
      .insn     (i_opcode_in),
      .dec_c    (dec_c),
      .uses_a_c (uses_a_c),
      .uses_b_c (uses_b_c)
   );

   // RAW check against the output register and every live scoreboard entry
   always_comb begin
      match_a = valid_q && out_q.wb_en && (out_q.rd == dec_c.rsa);
      match_b = valid_q && out_q.wb_en && (out_q.rd == dec_c.rsb);
      for (int unsigned i = 0; i < HZ_DEPTH; i++) begin
         if (sb_q[i].valid && (sb_q[i].rd == dec_c.rsa)) match_a = 1'b1;
         if (sb_q[i].valid && (sb_q[i].rd == dec_c.rsb)) match_b = 1'b1;
      end
      hazard = i_valid && ((uses_a_c && (dec_c.rsa != '0) && match_a)
                        || (uses_b_c && (dec_c.rsb != '0) && match_b));
   end

   assign o_ready = !i_flush && !hazard && (!valid_q || i_ready);
   assign accept  = i_valid && o_ready;

   // Flush kills only the output register; scoreboard entries predate the branch
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         out_q   <= '0;
         pc_q    <= '0;
         for (int unsigned i = 0; i < HZ_DEPTH; i++) sb_q[i] <= '0;
      end else begin
         if (i_ready) begin
            sb_q[0] <= '{valid: valid_q && out_q.wb_en && (out_q.rd != '0), rd: out_q.rd};
            for (int unsigned i = 1; i < HZ_DEPTH; i++) sb_q[i] <= sb_q[i-1];
         end
         if (accept) begin
            valid_q <= 1'b1;
            out_q   <= dec_c;
            pc_q    <= i_pc;
         end else if (i_ready || i_flush) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_valid     = valid_q;
   assign o_pc        = pc_q;
   assign o_immediate = out_q.immediate;
   assign o_opcode    = out_q.opcode;
   assign o_funct3    = out_q.funct3;
   assign o_funct7    = out_q.funct7;
   assign o_rsa       = out_q.rsa;
   assign o_rsb       = out_q.rsb;
   assign o_rd        = out_q.rd;
   assign o_system    = out_q.system;
   assign o_mul       = out_q.mul;
   assign o_illegal   = out_q.illegal;
   assign o_alu_pc    = out_q.alu_pc;
   assign o_alu_imm   = out_q.alu_imm;
   assign o_alu_en    = out_q.alu_en;
   assign o_ma_wr     = out_q.ma_wr;
   assign o_ma_rd     = out_q.ma_rd;
   assign o_wb_mux    = out_q.wb_mux;
   assign o_wb_en     = out_q.wb_en;

endmodule
